// File: rtl/uart_line_adapter.sv
// uart_line_adapter: connects a DUT's 8N1 UART pins to byte-wide streams.
//   RX path: uart_txd -> 2-flop synchronizer -> RX FSM -> byte FIFO -> serial_out_*
//   TX path: serial_in_* -> TX FSM -> uart_rxd
// The two paths share only clock and reset; they can run at the same time.
//
// Stream handshakes: a byte moves on a cycle where valid and ready are both 1
// at the rising clock edge. The source holds valid and bits steady until that
// edge. The sink may raise or drop ready at any time. serial_in_ready is 1
// only while the TX serializer is idle.
module uart_line_adapter #(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_txd,
    output logic       uart_rxd,
    output logic       serial_out_valid,
    input  logic       serial_out_ready,
    output logic [7:0] serial_out_bits,
    input  logic       serial_in_valid,
    output logic       serial_in_ready,
    input  logic [7:0] serial_in_bits,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int CW   = $clog2(DIV) + 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NW   = PW + 1;
    // A counter holds the number of cycles left before the next event.
    // START waits half a bit. Every later wait is a full bit and is loaded as
    // DIV-1 because the reload happens in the cycle of the event itself.
    localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);

    // ---------------------------------------------------------------- sync
    logic sync_1, sync_2;
    logic rxs;

    // Two-flop synchronizer for the asynchronous DUT TX line; resets to idle-high
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= uart_txd;
            sync_2 <= sync_1;
        end
    end

    assign rxs = sync_2;

    // ---------------------------------------------------------------- RX FSM
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tick;
    logic            rx_push;
    logic            rx_frame;

    assign rx_tick = (rx_cnt == '0);

    // RX state register plus its bit counter, sample counter and shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= HALF_BIT;
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_cnt <= FULL_BIT;
                        rx_bit <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= FULL_BIT;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (!rx_tick) begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                default: begin
                    rx_cnt <= rx_cnt;
                end
            endcase
        end
    end

    // RX next state: find the start bit at mid-bit, take 8 data bits, check the stop bit
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxs) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: push a good byte, or flag a bad stop bit, at the stop-bit sample
    always_comb begin
        rx_push  = 1'b0;
        rx_frame = 1'b0;
        if ((rx_state == RX_STOP) && rx_tick) begin
            rx_push  = rxs;
            rx_frame = !rxs;
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] fifo_count;
    logic          fifo_pop;
    logic          push_ok;

    assign serial_out_valid = (fifo_count != '0);
    assign serial_out_bits  = fifo_mem[rd_ptr];
    assign fifo_pop         = serial_out_valid && serial_out_ready;
    // A full FIFO can still take a byte when the head leaves in the same cycle
    assign push_ok          = rx_push && ((fifo_count != NW'(FIFO_DEPTH)) || fifo_pop);

    // FIFO storage; the array needs no reset because the count tracks valid entries
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    // FIFO pointers (power-of-two depth, so they wrap naturally) and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, fifo_pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Error pulses, each registered so it appears the cycle after the event
    always_ff @(posedge clock) begin
        if (reset) begin
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= rx_frame;
            overrun_err <= rx_push && !push_ok;
        end
    end

    // ---------------------------------------------------------------- TX FSM
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick;
    logic          tx_go;

    assign tx_tick = (tx_cnt == '0);
    assign tx_go   = serial_in_valid && serial_in_ready;

    // TX state register plus bit timer, bit index and outgoing shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_go) begin
                        tx_shift <= serial_in_bits;
                        tx_cnt   <= FULL_BIT;
                        tx_bit   <= '0;
                    end
                end
                TX_START: begin
                    tx_cnt <= tx_tick ? FULL_BIT : tx_cnt - CW'(1);
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt   <= FULL_BIT;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt - CW'(1);
                    end
                end
                default: begin
                    if (!tx_tick) tx_cnt <= tx_cnt - CW'(1);
                end
            endcase
        end
    end

    // TX next state: each phase lasts one bit time; DATA repeats for 8 bits
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_go) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX outputs: line level for the current phase; ready is held low during reset
    always_comb begin
        serial_in_ready = (tx_state == TX_IDLE) && !reset;
        case (tx_state)
            TX_START: uart_rxd = 1'b0;
            TX_DATA:  uart_rxd = tx_shift[0];
            default:  uart_rxd = 1'b1;
        endcase
    end

endmodule
